// File: rtl/io_periph_pkg.sv
// io_map_pkg: shared IO page address map, data widths, decode selector type
// and the hex-digit to seven-segment glyph lookup used by io_periph.
package io_map_pkg;

    localparam int IO_ADDR_W = 10;
    localparam int IO_DATA_W = 24;

    localparam logic [IO_ADDR_W-1:0] IO_LED_LO = 10'h060;
    localparam logic [IO_ADDR_W-1:0] IO_LED_HI = 10'h062;
    localparam logic [IO_ADDR_W-1:0] IO_SW_LO  = 10'h070;
    localparam logic [IO_ADDR_W-1:0] IO_SW_HI  = 10'h072;
    localparam logic [IO_ADDR_W-1:0] IO_SEG    = 10'h080;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_LED_LO,
        SEL_LED_HI,
        SEL_SW_LO,
        SEL_SW_HI,
        SEL_SEG
    } io_sel_e;

    // Active-low cathodes {dp, g, f, e, d, c, b, a}; dp is kept dark.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] glyph;
        case (nib)
            4'h0:    glyph = 8'hC0;
            4'h1:    glyph = 8'hF9;
            4'h2:    glyph = 8'hA4;
            4'h3:    glyph = 8'hB0;
            4'h4:    glyph = 8'h99;
            4'h5:    glyph = 8'h92;
            4'h6:    glyph = 8'h82;
            4'h7:    glyph = 8'hF8;
            4'h8:    glyph = 8'h80;
            4'h9:    glyph = 8'h90;
            4'hA:    glyph = 8'h88;
            4'hB:    glyph = 8'h83;
            4'hC:    glyph = 8'hC6;
            4'hD:    glyph = 8'hA1;
            4'hE:    glyph = 8'h86;
            default: glyph = 8'h8E;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/io_periph_if.sv
// io_periph_if: CPU IO port bus (address, read/write strobes, data both ways).
// The CPU side uses the master modport, the peripheral the slave modport.
interface io_periph_if;
    import io_map_pkg::*;

    logic [IO_ADDR_W-1:0] io_addr;
    logic                 io_read;
    logic                 io_write;
    logic [IO_DATA_W-1:0] io_wdata;
    logic [IO_DATA_W-1:0] io_rdata;

    modport master (
        output io_addr, io_read, io_write, io_wdata,
        input  io_rdata
    );

    modport slave (
        input  io_addr, io_read, io_write, io_wdata,
        output io_rdata
    );
endinterface

// File: rtl/io_periph_sw_debounce.sv
// sw_debounce: two-flop synchronizer followed by one counter shared by all
// bits; the synchronized vector is accepted only after it has held still
// for DEBOUNCE_CYCLES consecutive samples.
module sw_debounce
    import io_map_pkg::*;
#(
    parameter int DATA_W          = IO_DATA_W,
    parameter int DEBOUNCE_CYCLES = 230000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] i_sw,
    output logic [DATA_W-1:0] o_sw_stable
);
    localparam int              CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [DATA_W-1:0] r_sw_p0;
    logic [DATA_W-1:0] r_sw_p1;
    logic [DATA_W-1:0] r_sw_prev;
    logic [DATA_W-1:0] r_sw_stable;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_same;

    // Bring the asynchronous switches into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_p0 <= '0;
            r_sw_p1 <= '0;
        end else begin
            r_sw_p0 <= i_sw;
            r_sw_p1 <= r_sw_p0;
        end
    end

    // Any change restarts the hold count; otherwise count up and park at the top.
    always_comb begin
        w_same    = (r_sw_p1 == r_sw_prev);
        w_cnt_nxt = '0;
        if (w_same) begin
            w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
        end
    end

    // Track the previous sample, the counter, and accept the vector once the hold completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_prev   <= '0;
            r_cnt       <= '0;
            r_sw_stable <= '0;
        end else begin
            r_sw_prev <= r_sw_p1;
            r_cnt     <= w_cnt_nxt;
            if (w_same && (w_cnt_nxt == CNT_MAX)) begin
                r_sw_stable <= r_sw_p1;
            end
        end
    end

    assign o_sw_stable = r_sw_stable;

endmodule

// File: rtl/io_periph.sv
// io_periph: CPU IO-page responder. LED register writes commit on the clock
// edge that retires the store; reads are answered combinationally from
// registered LED/switch state. Define IO_SEG7_EN to add the seven-segment
// value register at 0x080 and the eight-digit multiplexed scanner.
module io_periph
    import io_map_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 230000
`ifdef IO_SEG7_EN
    ,
    parameter int SCAN_CYCLES     = 23000
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    io_periph_if.slave           bus,
    input  logic [IO_DATA_W-1:0] i_sw_in,
    output logic [IO_DATA_W-1:0] o_led_out
`ifdef IO_SEG7_EN
    ,
    output logic [7:0]           o_seg_an,
    output logic [7:0]           o_seg_cat
`endif
);
    io_sel_e              w_sel;
    logic [IO_DATA_W-1:0] w_sw_stable;
    logic [IO_DATA_W-1:0] w_rdata;
    logic [IO_DATA_W-1:0] r_led;

    sw_debounce #(
        .DATA_W          (IO_DATA_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sw_debounce (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_sw        (i_sw_in),
        .o_sw_stable (w_sw_stable)
    );

    // Decode the full IO-page offset; anything not listed is unmapped.
    always_comb begin
        w_sel = SEL_NONE;
        case (bus.io_addr)
            IO_LED_LO: w_sel = SEL_LED_LO;
            IO_LED_HI: w_sel = SEL_LED_HI;
            IO_SW_LO:  w_sel = SEL_SW_LO;
            IO_SW_HI:  w_sel = SEL_SW_HI;
`ifdef IO_SEG7_EN
            IO_SEG:    w_sel = SEL_SEG;
`endif
            default:   w_sel = SEL_NONE;
        endcase
    end

    // LED register: each half is written independently, other bits hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led <= '0;
        end else if (bus.io_write) begin
            if (w_sel == SEL_LED_LO) r_led[15:0]  <= bus.io_wdata[15:0];
            if (w_sel == SEL_LED_HI) r_led[23:16] <= bus.io_wdata[7:0];
        end
    end

`ifdef IO_SEG7_EN
    localparam int               SCAN_W   = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_CYCLES - 1);

    logic [31:0]       r_seg;
    logic [SCAN_W-1:0] r_scan_cnt;
    logic [2:0]        r_digit;
    logic [3:0]        w_nib;
    logic [7:0]        r_seg_an;
    logic [7:0]        r_seg_cat;

    // Seven-segment value register; the top byte is always zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= '0;
        end else if (bus.io_write && (w_sel == SEL_SEG)) begin
            r_seg <= {8'h00, bus.io_wdata};
        end
    end

    // Dwell SCAN_CYCLES on each digit, then step to the next (7 wraps to 0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
            r_digit    <= '0;
        end else if (r_scan_cnt == SCAN_MAX) begin
            r_scan_cnt <= '0;
            r_digit    <= r_digit + 3'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
        end
    end

    // Nibble shown on the active digit.
    always_comb begin
        w_nib = r_seg[{r_digit, 2'b00} +: 4];
    end

    // Registered drivers so everything is dark while reset is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_an  <= 8'hFF;
            r_seg_cat <= 8'hFF;
        end else begin
            r_seg_an  <= ~(8'h01 << r_digit);
            r_seg_cat <= hex_to_seg(w_nib);
        end
    end

    assign o_seg_an  = r_seg_an;
    assign o_seg_cat = r_seg_cat;
`else
    // Only LED halves consume write data without the segment register.
    logic w_unused_wdata;
    assign w_unused_wdata = &{1'b0, bus.io_wdata[23:16]};
`endif

    // Read mux; returns zero unless a mapped register is being read.
    always_comb begin
        w_rdata = '0;
        if (bus.io_read) begin
            case (w_sel)
                SEL_LED_LO: w_rdata = {8'h00,  r_led[15:0]};
                SEL_LED_HI: w_rdata = {16'h0000, r_led[23:16]};
                SEL_SW_LO:  w_rdata = {8'h00,  w_sw_stable[15:0]};
                SEL_SW_HI:  w_rdata = {16'h0000, w_sw_stable[23:16]};
`ifdef IO_SEG7_EN
                SEL_SEG:    w_rdata = r_seg[23:0];
`endif
                default:    w_rdata = '0;
            endcase
        end
    end

    assign bus.io_rdata = w_rdata;
    assign o_led_out    = r_led;

endmodule
